// File: rtl/xc_malu_seq.sv
// ---------------------------------------------------------------------------
// xc_malu_seq
//
// Sequencer and state owner for the multi-cycle MALU step datapath
// (mul/div/rem/pmul). Takes one op from the core, keeps count/acc/arg_0/arg_1,
// shows them to the datapath every cycle and commits the datapath's next-state
// values. It also contains the packed adder that serves the datapath's padd_*
// requests, and returns the 64-bit result on a response channel.
//
// Optional feature macro: XC_MALU_SEQ_TIMEOUT_EN
//   defined   : a RUN that reaches count == MAX_STEPS without dp_ready ends in
//               DONE with rsp_err = 1 and rsp_result = 0.
//   undefined : no timeout. RUN waits for dp_ready indefinitely and rsp_err
//               stays 0.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   flush                   abandon any in-flight op; the next state is IDLE
//   req_valid/req_ready     op request handshake
//   req_op[9:0]             {do_div,divu,rem,remu,mul,mulu,mulsu,clmul,pmul,pclmul}
//   req_pw[4:0]             {pw_32,pw_16,pw_8,pw_4,pw_2}
//   req_rs1/2/3             operands
//   rsp_valid/rsp_ready     response handshake
//   rsp_result[63:0]        result
//   rsp_err                 op aborted by timeout
//   dp_valid                high while in RUN
//   dp_flush                follows flush for the cycle it is asserted
//   dp_op/dp_pw/dp_rs1..3   latched request
//   count/acc/arg_0/arg_1   step state presented to the datapath
//   n_acc/n_arg_0/n_arg_1   next step state from the datapath
//   dp_ready/dp_result      datapath has finished, with its result
//   padd_*                  packed adder request and answer
//   dbg_state               FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A valid source holds its payload stable until that transfer.
// ready may depend combinationally on state and flush, but not on valid.
// ---------------------------------------------------------------------------
module xc_malu_seq #(
  parameter int MAX_STEPS = 40,
  parameter int CW        = 6
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [9:0]    req_op,
  input  logic [4:0]    req_pw,
  input  logic [31:0]   req_rs1,
  input  logic [31:0]   req_rs2,
  input  logic [31:0]   req_rs3,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [63:0]   rsp_result,
  output logic          rsp_err,
  output logic          dp_valid,
  output logic          dp_flush,
  output logic [9:0]    dp_op,
  output logic [4:0]    dp_pw,
  output logic [31:0]   dp_rs1,
  output logic [31:0]   dp_rs2,
  output logic [31:0]   dp_rs3,
  output logic [CW-1:0] count,
  output logic [63:0]   acc,
  output logic [31:0]   arg_0,
  output logic [31:0]   arg_1,
  input  logic [63:0]   n_acc,
  input  logic [31:0]   n_arg_0,
  input  logic [31:0]   n_arg_1,
  input  logic          dp_ready,
  input  logic [63:0]   dp_result,
  input  logic [31:0]   padd_lhs,
  input  logic [31:0]   padd_rhs,
  input  logic          padd_sub,
  input  logic          padd_cin,
  input  logic          padd_cen,
  output logic [31:0]   padd_cout,
  output logic [31:0]   padd_result,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

`ifdef XC_MALU_SEQ_TIMEOUT_EN
  localparam logic TIMEOUT_EN = 1'b1;
`else
  localparam logic TIMEOUT_EN = 1'b0;
`endif

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_STEPS);

  state_e        state_q,  state_d;
  logic [9:0]    op_q,     op_d;
  logic [4:0]    pw_q,     pw_d;
  logic [31:0]   rs1_q,    rs1_d;
  logic [31:0]   rs2_q,    rs2_d;
  logic [31:0]   rs3_q,    rs3_d;
  logic [CW-1:0] count_q,  count_d;
  logic [63:0]   acc_q,    acc_d;
  logic [31:0]   arg0_q,   arg0_d;
  logic [31:0]   arg1_q,   arg1_d;
  logic [63:0]   result_q, result_d;
  logic          err_q,    err_d;

  logic          timeout_hit;

  assign timeout_hit = TIMEOUT_EN && (count_q == MAX_CNT);

  // ------------------------------------------------------------------------
  // Next-state and handshake logic
  // ------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    pw_d     = pw_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rs3_d    = rs3_q;
    count_d  = count_q;
    acc_d    = acc_q;
    arg0_d   = arg0_q;
    arg1_d   = arg1_q;
    result_d = result_q;
    err_d    = err_q;

    req_ready = (state_q == ST_IDLE) && !flush;
    dp_valid  = (state_q == ST_RUN);
    // Not offered during a flush, so a response being discarded can never
    // complete a handshake.
    rsp_valid = (state_q == ST_DONE) && !flush;
    dp_flush  = flush;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          op_d    = req_op;
          pw_d    = req_pw;
          rs1_d   = req_rs1;
          rs2_d   = req_rs2;
          rs3_d   = req_rs3;
          count_d = '0;
          acc_d   = '0;
          arg0_d  = '0;
          arg1_d  = '0;
          err_d   = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (dp_ready) begin
          result_d = dp_result;
          err_d    = 1'b0;
          state_d  = ST_DONE;
        end else if (timeout_hit) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = ST_DONE;
        end else begin
          acc_d  = n_acc;
          arg0_d = n_arg_0;
          arg1_d = n_arg_1;
          // The counter saturates instead of wrapping, so a long run never
          // looks like a fresh one.
          if (count_q != '1) begin
            count_d = count_q + CW'(1);
          end
        end
      end
      ST_DONE: begin
        // req_ready is low in DONE, so the handshake cycle cannot also accept.
        if (rsp_ready) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // flush takes priority over everything else and clears like reset.
    if (flush) begin
      state_d  = ST_IDLE;
      op_d     = '0;
      pw_d     = '0;
      rs1_d    = '0;
      rs2_d    = '0;
      rs3_d    = '0;
      count_d  = '0;
      acc_d    = '0;
      arg0_d   = '0;
      arg1_d   = '0;
      result_d = '0;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      pw_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rs3_q    <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      arg0_q   <= '0;
      arg1_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      pw_q     <= pw_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rs3_q    <= rs3_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      arg0_q   <= arg0_d;
      arg1_q   <= arg1_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign rsp_result = result_q;
  assign rsp_err    = err_q;
  assign dp_op      = op_q;
  assign dp_pw      = pw_q;
  assign dp_rs1     = rs1_q;
  assign dp_rs2     = rs2_q;
  assign dp_rs3     = rs3_q;
  assign count      = count_q;
  assign acc        = acc_q;
  assign arg_0      = arg0_q;
  assign arg_1      = arg1_q;
  assign dbg_state  = state_q;

  // ------------------------------------------------------------------------
  // Packed adder
  // ------------------------------------------------------------------------
  // lsb_mask marks the bits that start an element. A non-one-hot width
  // falls back to a single 32-bit element.
  logic [31:0] lsb_mask;

  always_comb begin
    case (pw_q)
      5'b10000: lsb_mask = 32'h0000_0001;
      5'b01000: lsb_mask = 32'h0001_0001;
      5'b00100: lsb_mask = 32'h0101_0101;
      5'b00010: lsb_mask = 32'h1111_1111;
      5'b00001: lsb_mask = 32'h5555_5555;
      default:  lsb_mask = 32'h0000_0001;
    endcase
  end

  // Ripple chain that restarts at every element LSB, so no carry crosses
  // into the next element. With cen low every carry is 0, which gives XOR.
  always_comb begin
    logic [31:0] r;
    logic        c;
    logic        prev;
    r           = padd_rhs ^ {32{padd_sub}};
    prev        = 1'b0;
    padd_result = '0;
    padd_cout   = '0;
    for (int i = 0; i < 32; i++) begin
      if (!padd_cen) begin
        c = 1'b0;
      end else if (lsb_mask[i]) begin
        c = padd_cin | padd_sub;
      end else begin
        c = prev;
      end
      padd_result[i] = padd_lhs[i] ^ r[i] ^ c;
      padd_cout[i]   = (padd_lhs[i] & r[i]) | (padd_lhs[i] & c) | (r[i] & c);
      prev           = padd_cout[i];
    end
  end

endmodule
